// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI voice scheduler.
//   - Status nibble constants for the channel messages that are decoded.
//   - Byte range limits for system-common and real-time bytes.
//   - Parser state encoding. IDLE is the reset value and means that no
//     running status is held.
package midi_pkg;

   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] PROG     = 4'hC;
   localparam logic [3:0] CHPRESS  = 4'hD;

   localparam logic [7:0] SYS_COMMON_MIN = 8'hF0;
   localparam logic [7:0] RT_MIN         = 8'hF8;

   localparam int AGE_W = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_D1 = 2'd1,
      WAIT_D2 = 2'd2
   } parse_state_t;

endpackage

// File: rtl/midi_voice_scheduler_if.sv
// Byte-stream and voice-bank bundle for midi_voice_scheduler.
//   rx_byte/rx_valid/rx_err : received MIDI bytes from the UART
//   voice_gate/start/stop   : per-voice gate level and 1-cycle strobes
//   voice_note/voice_vel    : 7 bits per voice, voice i at [7i+6:7i]
//   steal/msg_drop          : 1-cycle event strobes
// master = byte source / voice-bank side, slave = the scheduler.
interface midi_voice_scheduler_if #(
   parameter int NUM_VOICES = 4
);
   logic [7:0]              rx_byte;
   logic                    rx_valid;
   logic                    rx_err;
   logic [NUM_VOICES-1:0]   voice_gate;
   logic [7*NUM_VOICES-1:0] voice_note;
   logic [7*NUM_VOICES-1:0] voice_vel;
   logic [NUM_VOICES-1:0]   voice_start;
   logic [NUM_VOICES-1:0]   voice_stop;
   logic                    steal;
   logic                    msg_drop;

   modport master (
      output rx_byte, rx_valid, rx_err,
      input  voice_gate, voice_note, voice_vel, voice_start, voice_stop,
             steal, msg_drop
   );

   modport slave (
      input  rx_byte, rx_valid, rx_err,
      output voice_gate, voice_note, voice_vel, voice_start, voice_stop,
             steal, msg_drop
   );
endinterface

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser with running status.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   rx_byte, rx_valid   : received byte and its strobe
//   rx_err              : framing error strobe, overrides rx_valid
//   ev_valid            : combinational, a note event completes on this byte
//   ev_on               : 1 = note-on, 0 = note-off (incl. note-on vel 0)
//   ev_note, ev_vel     : note number and velocity of the event
//   msg_drop            : registered 1-cycle pulse, partial message discarded
// The event is combinational so the voice registers can take it on the same
// edge that consumes the final data byte.
module midi_msg_parser
   import midi_pkg::*;
#(
   parameter logic [3:0] CHANNEL = 4'd0,
   parameter bit         OMNI    = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   input  logic       rx_err,
   output logic       ev_valid,
   output logic       ev_on,
   output logic [6:0] ev_note,
   output logic [6:0] ev_vel,
   output logic       msg_drop
);

   parse_state_t state_q, state_n;
   logic [3:0]   rs_cmd_q, rs_cmd_n;
   logic [3:0]   rs_chan_q, rs_chan_n;
   logic [6:0]   d1_q, d1_n;
   logic         drop_n;
   logic         is_note;
   logic         chan_ok;

   assign is_note = (rs_cmd_q == NOTE_OFF) || (rs_cmd_q == NOTE_ON);
   assign chan_ok = OMNI || (rs_chan_q == CHANNEL);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rs_cmd_q  <= 4'd0;
         rs_chan_q <= 4'd0;
         msg_drop  <= 1'b0;
      end else begin
         state_q   <= state_n;
         rs_cmd_q  <= rs_cmd_n;
         rs_chan_q <= rs_chan_n;
         msg_drop  <= drop_n;
      end
   end

   // First data byte is only meaningful while state_q is WAIT_D2.
   always_ff @(posedge clk) begin
      d1_q <= d1_n;
   end

   always_comb begin
      state_n   = state_q;
      rs_cmd_n  = rs_cmd_q;
      rs_chan_n = rs_chan_q;
      d1_n      = d1_q;
      drop_n    = 1'b0;
      ev_valid  = 1'b0;
      ev_on     = 1'b0;
      ev_note   = d1_q;
      ev_vel    = rx_byte[6:0];

      if (rx_err) begin
         // Running status is held exactly when the parser is not IDLE.
         drop_n  = (state_q == WAIT_D2);
         state_n = (state_q == IDLE) ? IDLE : WAIT_D1;
      end else if (rx_valid) begin
         if (rx_byte >= RT_MIN) begin
            // Real-time bytes are transparent to the parser.
            state_n = state_q;
         end else if (rx_byte >= SYS_COMMON_MIN) begin
            drop_n    = (state_q == WAIT_D2);
            state_n   = IDLE;
            rs_cmd_n  = 4'd0;
            rs_chan_n = 4'd0;
         end else if (rx_byte[7]) begin
            drop_n    = (state_q == WAIT_D2);
            state_n   = WAIT_D1;
            rs_cmd_n  = rx_byte[7:4];
            rs_chan_n = rx_byte[3:0];
         end else begin
            unique case (state_q)
               WAIT_D1: begin
                  // Single-data-byte messages complete here and keep status.
                  if ((rs_cmd_q != PROG) && (rs_cmd_q != CHPRESS)) begin
                     d1_n    = rx_byte[6:0];
                     state_n = WAIT_D2;
                  end
               end
               WAIT_D2: begin
                  state_n  = WAIT_D1;
                  ev_valid = is_note && chan_ok;
                  ev_on    = (rs_cmd_q == NOTE_ON) && (rx_byte[6:0] != 7'd0);
               end
               default: state_n = IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/midi_voice_scheduler.sv
// MIDI note parser plus sampler voice allocator.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : midi_voice_scheduler_if slave (byte stream in, voice bank out)
// Allocation for note-on: retrigger a gated voice holding the same note,
// else the lowest free voice, else steal the oldest gated voice. Ages
// saturate at NUM_VOICES-1 and only matter while a voice is gated.
module midi_voice_scheduler
   import midi_pkg::*;
#(
   parameter int         NUM_VOICES = 4,
   parameter logic [3:0] CHANNEL    = 4'd0,
   parameter bit         OMNI       = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   midi_voice_scheduler_if.slave  bus
);

   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

   function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
      if (a >= AGE_MAX) return AGE_MAX;
      return a + AGE_W'(1);
   endfunction

   logic       vld_p0;
   logic       ev_on_p0;
   logic [6:0] ev_note_p0;
   logic [6:0] ev_vel_p0;

   midi_msg_parser #(
      .CHANNEL (CHANNEL),
      .OMNI    (OMNI)
   ) u_parser (
      .clk      (clk),
      .rst      (rst),
      .rx_byte  (bus.rx_byte),
      .rx_valid (bus.rx_valid),
      .rx_err   (bus.rx_err),
      .ev_valid (vld_p0),
      .ev_on    (ev_on_p0),
      .ev_note  (ev_note_p0),
      .ev_vel   (ev_vel_p0),
      .msg_drop (bus.msg_drop)
   );

   // ---- stage p0 -> p1: allocation decision, voice state registered ----
   logic [NUM_VOICES-1:0] gate_p1, gate_n;
   logic [NUM_VOICES-1:0] start_p1, start_n;
   logic [NUM_VOICES-1:0] stop_p1, stop_n;
   logic                  steal_p1, steal_n;
   logic [6:0]            note_p1 [NUM_VOICES];
   logic [6:0]            note_n  [NUM_VOICES];
   logic [6:0]            vel_p1  [NUM_VOICES];
   logic [6:0]            vel_n   [NUM_VOICES];
   logic [AGE_W-1:0]      age_p1  [NUM_VOICES];
   logic [AGE_W-1:0]      age_n   [NUM_VOICES];

   logic hit, any_free;
   int   hit_idx, free_idx, old_idx, sel;

   // Candidate search. Descending loops leave the lowest index winning;
   // the strict '>' in the age scan keeps ties at the lowest index.
   always_comb begin
      hit      = 1'b0;
      any_free = 1'b0;
      hit_idx  = 0;
      free_idx = 0;
      old_idx  = 0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (gate_p1[i] && (note_p1[i] == ev_note_p0)) begin
            hit     = 1'b1;
            hit_idx = i;
         end
         if (!gate_p1[i]) begin
            any_free = 1'b1;
            free_idx = i;
         end
      end
      for (int i = 1; i < NUM_VOICES; i++) begin
         if (age_p1[i] > age_p1[old_idx]) old_idx = i;
      end
   end

   always_comb begin
      gate_n  = gate_p1;
      note_n  = note_p1;
      vel_n   = vel_p1;
      age_n   = age_p1;
      start_n = '0;
      stop_n  = '0;
      steal_n = 1'b0;
      sel     = hit ? hit_idx : (any_free ? free_idx : old_idx);

      if (vld_p0 && ev_on_p0) begin
         steal_n = !hit && !any_free;
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (i == sel) begin
               gate_n[i]  = 1'b1;
               note_n[i]  = ev_note_p0;
               vel_n[i]   = ev_vel_p0;
               age_n[i]   = '0;
               start_n[i] = 1'b1;
            end else if (gate_p1[i]) begin
               age_n[i] = age_inc(age_p1[i]);
            end
         end
      end else if (vld_p0) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (gate_p1[i] && (note_p1[i] == ev_note_p0)) begin
               gate_n[i] = 1'b0;
               stop_n[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gate_p1  <= '0;
         start_p1 <= '0;
         stop_p1  <= '0;
         steal_p1 <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            note_p1[i] <= '0;
            vel_p1[i]  <= '0;
            age_p1[i]  <= '0;
         end
      end else begin
         gate_p1  <= gate_n;
         start_p1 <= start_n;
         stop_p1  <= stop_n;
         steal_p1 <= steal_n;
         note_p1  <= note_n;
         vel_p1   <= vel_n;
         age_p1   <= age_n;
      end
   end

   logic [7*NUM_VOICES-1:0] note_pk, vel_pk;

   always_comb begin
      note_pk = '0;
      vel_pk  = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         note_pk[7*i +: 7] = note_p1[i];
         vel_pk[7*i +: 7]  = vel_p1[i];
      end
   end

   assign bus.voice_gate  = gate_p1;
   assign bus.voice_start = start_p1;
   assign bus.voice_stop  = stop_p1;
   assign bus.steal       = steal_p1;
   assign bus.voice_note  = note_pk;
   assign bus.voice_vel   = vel_pk;

endmodule
